// File: rtl/scope_trigger_capture_pkg.sv
// Shared types and constants for the scope trigger/capture block.
package scope_trigger_capture_pkg;

    localparam int ADC_W    = 12;
    localparam int VGA_COLS = 640;

    typedef enum logic [2:0] {
        ST_ARM,
        ST_WAIT_LOW,
        ST_WAIT_CROSS,
        ST_CAPTURE,
        ST_HOLD
    } state_t;

endpackage

// File: rtl/scope_trigger_capture_ram.sv
// Frame buffer: one synchronous write port, one registered read port (1-cycle latency).
// Only the read register is reset; the array itself keeps its contents.
module scope_trigger_capture_ram
    import scope_trigger_capture_pkg::*;
#(
    parameter int DEPTH = VGA_COLS,
    parameter int AW    = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we_i,
    input  logic [AW-1:0]    waddr_i,
    input  logic [ADC_W-1:0] wdata_i,
    input  logic [AW-1:0]    raddr_i,
    output logic [ADC_W-1:0] rdata_o
);

    logic [ADC_W-1:0] mem [DEPTH];
    logic [ADC_W-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/scope_trigger_capture.sv
// Hysteresis level trigger with timeout auto-trigger; captures DEPTH decimated samples
// into a frame buffer and holds them for the VGA reader until frame_done.
module scope_trigger_capture
    import scope_trigger_capture_pkg::*;
#(
    parameter int DEPTH   = VGA_COLS,
    parameter int AW      = 10,
    parameter int HYST    = 16,
    parameter int DECIM   = 1,
    parameter int TIMEOUT = 2500000,
    parameter int MIN_AMP = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [ADC_W-1:0] voltage,
    input  logic             sample_valid,
    input  logic [ADC_W-1:0] dc_offset,
    input  logic [ADC_W-1:0] amp,
    input  logic [AW-1:0]    rd_addr,
    output logic [ADC_W-1:0] rd_data,
    output logic             frame_ready,
    input  logic             frame_done,
    output logic             auto_trig,
    output logic             armed
);

    localparam int               DCW       = (DECIM > 1) ? $clog2(DECIM) : 1;
    localparam logic [DCW-1:0]   DEC_LAST  = DCW'(DECIM - 1);
    localparam logic [31:0]      TMO_LAST  = 32'(TIMEOUT - 1);
    localparam logic [AW-1:0]    WR_LAST   = AW'(DEPTH - 1);
    localparam logic [ADC_W-1:0] HYST_C    = ADC_W'(HYST);
    localparam logic [ADC_W-1:0] MIN_AMP_C = ADC_W'(MIN_AMP);

    state_t           state_q, state_d;
    logic [DCW-1:0]   dec_q, dec_d;
    logic [31:0]      tmo_q, tmo_d;
    logic [AW-1:0]    wr_addr_q, wr_addr_d;
    logic [ADC_W-1:0] level_q, level_d;
    logic [ADC_W-1:0] low_q, low_d;
    logic             flat_q, flat_d;
    logic             auto_q, auto_d;

    logic             accept;
    logic             level_hit;
    logic             we;
    logic [AW-1:0]    waddr;

    // ARM and HOLD never consume samples, so their strobes are not counted either.
    assign accept    = sample_valid && (dec_q == DEC_LAST)
                       && (state_q != ST_ARM) && (state_q != ST_HOLD);
    assign level_hit = (state_q == ST_WAIT_CROSS) && (voltage >= level_q);

    always_comb begin
        state_d   = state_q;
        dec_d     = dec_q;
        tmo_d     = tmo_q;
        wr_addr_d = wr_addr_q;
        level_d   = level_q;
        low_d     = low_q;
        flat_d    = flat_q;
        auto_d    = auto_q;
        we        = 1'b0;
        waddr     = wr_addr_q;

        if (state_q == ST_ARM) begin
            dec_d = '0;
        end else if (sample_valid) begin
            dec_d = (dec_q == DEC_LAST) ? '0 : dec_q + 1'b1;
        end

        case (state_q)
            ST_ARM: begin
                level_d = dc_offset;
                low_d   = (dc_offset < HYST_C) ? '0 : dc_offset - HYST_C;
                flat_d  = (amp < MIN_AMP_C);
                tmo_d   = '0;
                state_d = ST_WAIT_LOW;
            end
            ST_WAIT_LOW, ST_WAIT_CROSS: begin
                if (accept) begin
                    // A level crossing takes priority over a simultaneous timeout.
                    if (level_hit || (tmo_q == TMO_LAST)) begin
                        we        = 1'b1;
                        waddr     = '0;
                        wr_addr_d = AW'(1);
                        auto_d    = !level_hit;
                        state_d   = ST_CAPTURE;
                    end else begin
                        tmo_d = tmo_q + 32'd1;
                        if ((state_q == ST_WAIT_LOW) && !flat_q && (voltage < low_q)) begin
                            state_d = ST_WAIT_CROSS;
                        end
                    end
                end
            end
            ST_CAPTURE: begin
                if (accept) begin
                    we        = 1'b1;
                    wr_addr_d = wr_addr_q + 1'b1;
                    if (wr_addr_q == WR_LAST) begin
                        state_d = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                if (frame_done) begin
                    state_d = ST_ARM;
                end
            end
            default: state_d = ST_ARM;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_ARM;
            dec_q     <= '0;
            tmo_q     <= '0;
            wr_addr_q <= '0;
            level_q   <= '0;
            low_q     <= '0;
            flat_q    <= 1'b0;
            auto_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            dec_q     <= dec_d;
            tmo_q     <= tmo_d;
            wr_addr_q <= wr_addr_d;
            level_q   <= level_d;
            low_q     <= low_d;
            flat_q    <= flat_d;
            auto_q    <= auto_d;
        end
    end

    scope_trigger_capture_ram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk     (clk),
        .rst     (rst),
        .we_i    (we),
        .waddr_i (waddr),
        .wdata_i (voltage),
        .raddr_i (rd_addr),
        .rdata_o (rd_data)
    );

    assign frame_ready = (state_q == ST_HOLD);
    assign armed       = (state_q == ST_WAIT_LOW) || (state_q == ST_WAIT_CROSS);
    assign auto_trig   = auto_q;

endmodule

// File: tb/tb_scope_trigger_capture.sv
// Directed bench: two instances (DECIM=1 and DECIM=4, TIMEOUT=1000) on shared stimulus.
module tb_scope_trigger_capture;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [11:0] voltage = '0;
    logic        sample_valid = 1'b0;
    logic [11:0] dc_offset = 12'd2048;
    logic [11:0] amp = 12'd1000;
    logic [9:0]  rd_addr = '0;
    logic        frame_done = 1'b0;

    logic [11:0] rd_data1, rd_data4;
    logic        frame_ready1, frame_ready4;
    logic        auto_trig1, auto_trig4;
    logic        armed1, armed4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    scope_trigger_capture #(
        .DEPTH(640), .AW(10), .HYST(16), .DECIM(1), .TIMEOUT(1000), .MIN_AMP(32)
    ) dut (
        .clk(clk), .rst(rst), .voltage(voltage), .sample_valid(sample_valid),
        .dc_offset(dc_offset), .amp(amp), .rd_addr(rd_addr), .rd_data(rd_data1),
        .frame_ready(frame_ready1), .frame_done(frame_done),
        .auto_trig(auto_trig1), .armed(armed1)
    );

    scope_trigger_capture #(
        .DEPTH(640), .AW(10), .HYST(16), .DECIM(4), .TIMEOUT(1000), .MIN_AMP(32)
    ) dut4 (
        .clk(clk), .rst(rst), .voltage(voltage), .sample_valid(sample_valid),
        .dc_offset(dc_offset), .amp(amp), .rd_addr(rd_addr), .rd_data(rd_data4),
        .frame_ready(frame_ready4), .frame_done(frame_done),
        .auto_trig(auto_trig4), .armed(armed4)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [11:0] v);
        voltage      = v;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        tick();
        tick();
    endtask

    task automatic read_at(input logic [9:0] a);
        rd_addr = a;
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        voltage = 12'd3000;
        sample_valid = 1'b1;
        tick();
        sample_valid = 1'b0;
        tick();
        checks++; if (frame_ready1 !== 1'b0) begin errors++; $display("FAIL reset_frame_ready got %b want 0", frame_ready1); end
        checks++; if (armed1 !== 1'b0) begin errors++; $display("FAIL reset_armed got %b want 0", armed1); end
        checks++; if (rd_data1 !== 12'd0) begin errors++; $display("FAIL reset_rd_data got %0d want 0", rd_data1); end
        checks++; if (auto_trig1 !== 1'b0) begin errors++; $display("FAIL reset_auto_trig got %b want 0", auto_trig1); end
        rst = 1'b0;
        tick();
        tick();
        checks++; if (armed1 !== 1'b1) begin errors++; $display("FAIL reset_rearm got %b want 1", armed1); end
    endtask

    task automatic test_level_trigger();
        dc_offset = 12'd2048;
        amp = 12'd1000;
        do_reset();
        for (int i = 0; i <= 1187; i++) begin
            send(12'(1500 + i));
            if (i == 547) begin
                checks++; if (armed1 !== 1'b1) begin errors++; $display("FAIL lvl_armed_before got %b want 1", armed1); end
            end
            if (i == 548) begin
                checks++; if (armed1 !== 1'b0) begin errors++; $display("FAIL lvl_trigger got armed %b want 0", armed1); end
            end
            if (i == 1186) begin
                checks++; if (frame_ready1 !== 1'b0) begin errors++; $display("FAIL lvl_ready_early got %b want 0", frame_ready1); end
            end
            if (i == 1187) begin
                checks++; if (frame_ready1 !== 1'b1) begin errors++; $display("FAIL lvl_ready got %b want 1", frame_ready1); end
            end
        end
        checks++; if (auto_trig1 !== 1'b0) begin errors++; $display("FAIL lvl_auto_trig got %b want 0", auto_trig1); end
        read_at(10'd0);
        checks++; if (rd_data1 !== 12'd2048) begin errors++; $display("FAIL lvl_mem0 got %0d want 2048", rd_data1); end
        read_at(10'd320);
        checks++; if (rd_data1 !== 12'd2368) begin errors++; $display("FAIL lvl_mem320 got %0d want 2368", rd_data1); end
        read_at(10'd639);
        checks++; if (rd_data1 !== 12'd2687) begin errors++; $display("FAIL lvl_mem639 got %0d want 2687", rd_data1); end
        checks++; if (frame_ready1 !== 1'b1) begin errors++; $display("FAIL lvl_hold got %b want 1", frame_ready1); end
    endtask

    task automatic test_hysteresis();
        dc_offset = 12'd2048;
        amp = 12'd1000;
        do_reset();
        for (int i = 0; i <= 1638; i++) begin
            send(12'(2040 + (i % 16)));
            if (i == 998) begin
                checks++; if (armed1 !== 1'b1) begin errors++; $display("FAIL hyst_no_trigger got armed %b want 1", armed1); end
            end
            if (i == 999) begin
                checks++; if (armed1 !== 1'b0) begin errors++; $display("FAIL hyst_timeout got armed %b want 0", armed1); end
            end
        end
        checks++; if (frame_ready1 !== 1'b1) begin errors++; $display("FAIL hyst_ready got %b want 1", frame_ready1); end
        checks++; if (auto_trig1 !== 1'b1) begin errors++; $display("FAIL hyst_auto_trig got %b want 1", auto_trig1); end
        read_at(10'd0);
        checks++; if (rd_data1 !== 12'd2047) begin errors++; $display("FAIL hyst_mem0 got %0d want 2047", rd_data1); end
        read_at(10'd639);
        checks++; if (rd_data1 !== 12'd2046) begin errors++; $display("FAIL hyst_mem639 got %0d want 2046", rd_data1); end
    endtask

    task automatic test_flat_auto();
        dc_offset = 12'd2048;
        amp = 12'd10;
        do_reset();
        for (int i = 0; i <= 1638; i++) begin
            send((i % 2 == 1) ? 12'd3000 : 12'd1000);
            if (i == 998) begin
                checks++; if (armed1 !== 1'b1) begin errors++; $display("FAIL flat_ignored got armed %b want 1", armed1); end
            end
            if (i == 999) begin
                checks++; if (armed1 !== 1'b0) begin errors++; $display("FAIL flat_timeout got armed %b want 0", armed1); end
            end
        end
        checks++; if (frame_ready1 !== 1'b1) begin errors++; $display("FAIL flat_ready got %b want 1", frame_ready1); end
        checks++; if (auto_trig1 !== 1'b1) begin errors++; $display("FAIL flat_auto_trig got %b want 1", auto_trig1); end
        read_at(10'd0);
        checks++; if (rd_data1 !== 12'd3000) begin errors++; $display("FAIL flat_mem0 got %0d want 3000", rd_data1); end
        read_at(10'd1);
        checks++; if (rd_data1 !== 12'd1000) begin errors++; $display("FAIL flat_mem1 got %0d want 1000", rd_data1); end
        amp = 12'd1000;
    endtask

    task automatic test_decim_handshake();
        dc_offset = 12'd2048;
        amp = 12'd1000;
        do_reset();
        for (int i = 0; i <= 3107; i++) begin
            send((i < 1000) ? 12'(1500 + i) : 12'd2500);
            if (i == 550) begin
                checks++; if (armed4 !== 1'b1) begin errors++; $display("FAIL dec_armed_before got %b want 1", armed4); end
            end
            if (i == 551) begin
                checks++; if (armed4 !== 1'b0) begin errors++; $display("FAIL dec_trigger got armed %b want 0", armed4); end
            end
            if (i == 3106) begin
                checks++; if (frame_ready4 !== 1'b0) begin errors++; $display("FAIL dec_ready_early got %b want 0", frame_ready4); end
            end
            if (i == 3107) begin
                checks++; if (frame_ready4 !== 1'b1) begin errors++; $display("FAIL dec_ready got %b want 1", frame_ready4); end
            end
        end
        checks++; if (auto_trig4 !== 1'b0) begin errors++; $display("FAIL dec_auto_trig got %b want 0", auto_trig4); end
        read_at(10'd0);
        checks++; if (rd_data4 !== 12'd2051) begin errors++; $display("FAIL dec_mem0 got %0d want 2051", rd_data4); end

        voltage = 12'd100;
        sample_valid = 1'b1;
        frame_done = 1'b1;
        tick();
        sample_valid = 1'b0;
        frame_done = 1'b0;
        checks++; if (frame_ready4 !== 1'b0) begin errors++; $display("FAIL hs_ready_drop got %b want 0", frame_ready4); end
        checks++; if (armed4 !== 1'b0) begin errors++; $display("FAIL hs_arm_cycle got armed %b want 0", armed4); end
        tick();
        checks++; if (armed4 !== 1'b1) begin errors++; $display("FAIL hs_rearm got %b want 1", armed4); end
        for (int s = 1; s <= 8; s++) begin
            send((s <= 4) ? 12'd1000 : ((s <= 7) ? 12'd3000 : 12'd2100));
            if (s == 7) begin
                checks++; if (armed4 !== 1'b1) begin errors++; $display("FAIL hs_discard got armed %b want 1", armed4); end
            end
        end
        checks++; if (armed4 !== 1'b0) begin errors++; $display("FAIL hs_trigger got armed %b want 0", armed4); end
        read_at(10'd0);
        checks++; if (rd_data4 !== 12'd2100) begin errors++; $display("FAIL hs_mem0 got %0d want 2100", rd_data4); end
    endtask

    task automatic test_reset_mid_capture();
        dc_offset = 12'd2048;
        amp = 12'd1000;
        do_reset();
        for (int i = 0; i <= 847; i++) begin
            send(12'(1500 + i));
        end
        dc_offset = 12'd2100;
        rst = 1'b1;
        tick();
        checks++; if (frame_ready1 !== 1'b0) begin errors++; $display("FAIL mid_rst_ready got %b want 0", frame_ready1); end
        checks++; if (armed1 !== 1'b0) begin errors++; $display("FAIL mid_rst_armed got %b want 0", armed1); end
        rst = 1'b0;
        tick();
        for (int i = 0; i <= 1139; i++) begin
            send(12'(1600 + i));
            if (i == 499) begin
                checks++; if (armed1 !== 1'b1) begin errors++; $display("FAIL mid_armed_before got %b want 1", armed1); end
            end
            if (i == 1138) begin
                checks++; if (frame_ready1 !== 1'b0) begin errors++; $display("FAIL mid_ready_early got %b want 0", frame_ready1); end
            end
        end
        checks++; if (frame_ready1 !== 1'b1) begin errors++; $display("FAIL mid_ready got %b want 1", frame_ready1); end
        checks++; if (auto_trig1 !== 1'b0) begin errors++; $display("FAIL mid_auto_trig got %b want 0", auto_trig1); end
        read_at(10'd0);
        checks++; if (rd_data1 !== 12'd2100) begin errors++; $display("FAIL mid_mem0 got %0d want 2100", rd_data1); end
        read_at(10'd639);
        checks++; if (rd_data1 !== 12'd2739) begin errors++; $display("FAIL mid_mem639 got %0d want 2739", rd_data1); end
    endtask

    initial begin
        test_reset();
        test_level_trigger();
        test_hysteresis();
        test_flat_auto();
        test_decim_handshake();
        test_reset_mid_capture();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
